vending_machine_multi: RTL and testbench
========================================

# vending_machine_multi

Parametrised successor to the single-product-table vending FSM. It supports N products with runtime price and stock tables. Coins are accepted into a saturating credit register, and stock and price are checked on selection. Each dispensed product is handed off over a valid/ready handshake, and change or refunds are paid out coin-by-coin through a greedy denomination unit. The block sits between the coin-acceptor front end and the dispense/change actuators.

## Interface
- NUM_PRODUCTS, 4, number of products (≥2)
- CREDIT_W, 8, credit/price width; max credit = 2^CREDIT_W−1
- STOCK_W, 4, per-product stock counter width
- TIMEOUT_CYC, 255, idle cycles in COLLECT before auto-refund
- clk in 1: single clock, all logic rising-edge
- rst in 1: asynchronous, active-high reset
- coin_valid in 1: one-cycle coin pulse
- coin_value in 4: coin value in credit units
- coin_reject out 1: pulse, coin not accepted (returned mechanically)
- sel_valid in 1: product selection pulse
- sel_id in $clog2(NUM_PRODUCTS): selected product
- refund_req in 1: refund request pulse
- price_tbl in NUM_PRODUCTS*CREDIT_W: flattened prices, product k at bits [k*CREDIT_W +: CREDIT_W]
- restock_valid in 1, restock_id in $clog2(NUM_PRODUCTS), restock_qty in STOCK_W: add stock
- vend_valid out 1, vend_id out $clog2(NUM_PRODUCTS), vend_ready in 1: product handoff
- chg_valid out 1, chg_value out CREDIT_W, chg_ready in 1: change coin handoff
- sold_out out 1, insufficient out 1: one-cycle status pulses
- credit out CREDIT_W: current credit
- done out 1: one-cycle pulse on transaction end

## Operation
- States: IDLE, COLLECT, CHECK, VEND, CHANGE.
- IDLE: an accepted coin moves to COLLECT; credit = coin_value.
- COLLECT: coins accumulate. A coin that would overflow credit is rejected (coin_reject, credit unchanged).
- Every coin, selection or refund restarts the timeout counter. Counter reaching TIMEOUT_CYC acts as refund_req.
- COLLECT priority:
  - refund_req → CHANGE (any coin in the same cycle is accepted first and included in the refund).
  - else sel_valid → CHECK, with sel_id latched (a same-cycle coin counts toward the check).
- CHECK (one cycle):
  - stock[id]==0 → sold_out, back to COLLECT.
  - else credit < price → insufficient, back to COLLECT.
  - else credit −= price, stock[id] −= 1 → VEND.
  - Price is sampled from price_tbl in CHECK only.
- VEND: vend_valid=1, vend_id held until vend_ready. Then go to CHANGE if credit>0, else IDLE with done.
- CHANGE: chg_valid=1 with chg_value = largest of {10,5,1} ≤ credit. On chg_ready, credit −= chg_value. When credit reaches 0 → IDLE with done.
- Coins arriving in CHECK/VEND/CHANGE are rejected.
- Restock is accepted in any state: stock[id] saturates at 2^STOCK_W−1. A same-cycle restock and CHECK decrement on the same id apply both (net result).
- Reset: stock counters load 0. Products must be restocked before they can vend.

## Timing
- Reset values: all outputs 0, state IDLE, credit 0, all stock 0. Reset mid-transaction discards credit with no refund.
- Credit updates the cycle after an accepted coin. coin_reject is asserted in the coin cycle (combinational from coin_valid and state).
- sel_valid → CHECK next cycle → VEND/status pulse the cycle after. Minimum selection-to-vend_valid latency is 2 cycles.
- vend_valid/vend_id and chg_valid/chg_value stay stable until their ready is sampled high. A transfer occurs on the edge where valid&ready.
- done asserts the cycle state returns to IDLE.
- Pulses in states that do not accept them are ignored (sel/refund outside COLLECT; refund in IDLE with credit 0).

## Structure
- vm_pkg: state_t enum, denomination constants (10, 5, 1), and a helper function for price_tbl slicing.
- Sub-module vm_change_unit: combinational greedy selection, credit → chg_value.
- Stock array and timeout counter live in the top module.

## Test plan
- Restock id1 qty3, price1=15. Coins 10, 10, select 1 → vend_id=1; chg 5; credit 0; done; stock1=2.
- Exact money: price2=20, coins 10+10, select 2 → vend, no chg_valid, done one cycle after the vend handshake.
- Stock0=0, credit 12, select 0 → sold_out pulse, state COLLECT. Refund → chg 10 then chg 1, 1 (greedy 10,1,1); done.
- Credit 250 (CREDIT_W=8), coin 8 → coin_reject; credit stays 250.
- chg_ready held low 5 cycles → chg_valid and chg_value stable. Coin during CHANGE → coin_reject.
- No activity for 255 cycles with credit 7 → auto-refund: chg 5, 1, 1. Assert rst mid-CHANGE → all outputs 0 next cycle.

Source files
------------

// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared states, coin denominations and price table helper for the vending machine
package vm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_CHECK,
    S_VEND,
    S_CHANGE
  } state_t;

  localparam int unsigned DENOM_HI  = 10;
  localparam int unsigned DENOM_MID = 5;
  localparam int unsigned DENOM_LO  = 1;

  // Bit offset of product id inside the flattened price table.
  function automatic int unsigned price_lsb(input int unsigned id, input int unsigned credit_w);
    return id * credit_w;
  endfunction

endpackage

// File: rtl/vm_change_unit.sv
// rtl/vm_change_unit.sv - greedy change coin selection from the remaining credit
module vm_change_unit
  import vm_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] chg_value
);

  always_comb begin
    chg_value = '0;
    if (credit >= CREDIT_W'(DENOM_HI)) begin
      chg_value = CREDIT_W'(DENOM_HI);
    end else if (credit >= CREDIT_W'(DENOM_MID)) begin
      chg_value = CREDIT_W'(DENOM_MID);
    end else if (credit >= CREDIT_W'(DENOM_LO)) begin
      chg_value = CREDIT_W'(DENOM_LO);
    end
  end

endmodule

// File: rtl/vending_machine_multi.sv
// rtl/vending_machine_multi.sv - multi-product vending controller with runtime price/stock tables
module vending_machine_multi
  import vm_pkg::*;
#(
  parameter int NUM_PRODUCTS = 4,
  parameter int CREDIT_W     = 8,
  parameter int STOCK_W      = 4,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              coin_valid,
  input  logic [3:0]                        coin_value,
  output logic                              coin_reject,
  input  logic                              sel_valid,
  input  logic [$clog2(NUM_PRODUCTS)-1:0]   sel_id,
  input  logic                              refund_req,
  input  logic [NUM_PRODUCTS*CREDIT_W-1:0]  price_tbl,
  input  logic                              restock_valid,
  input  logic [$clog2(NUM_PRODUCTS)-1:0]   restock_id,
  input  logic [STOCK_W-1:0]                restock_qty,
  output logic                              vend_valid,
  output logic [$clog2(NUM_PRODUCTS)-1:0]   vend_id,
  input  logic                              vend_ready,
  output logic                              chg_valid,
  output logic [CREDIT_W-1:0]               chg_value,
  input  logic                              chg_ready,
  output logic                              sold_out,
  output logic                              insufficient,
  output logic [CREDIT_W-1:0]               credit,
  output logic                              done
);

  localparam int ID_W   = $clog2(NUM_PRODUCTS);
  localparam int PSLOTS = 1 << ID_W;
  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
  // Ids that address a real product; the rest of the id space is never stocked.
  localparam logic [PSLOTS-1:0] PROD_VALID = {PSLOTS{1'b1}} >> (PSLOTS - NUM_PRODUCTS);

  state_t               state_q, state_d;
  logic [CREDIT_W-1:0]  credit_q, credit_d;
  logic [ID_W-1:0]      sel_id_q, sel_id_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 done_q, done_d;
  logic                 sold_out_q, sold_out_d;
  logic                 insufficient_q, insufficient_d;

  logic [CREDIT_W:0]    coin_sum;
  logic                 coin_window;
  logic                 coin_accept;
  logic                 timeout;
  logic                 stock_dec;
  logic [CREDIT_W-1:0]  greedy_val;
  logic [CREDIT_W-1:0]  price_sel;

  logic [CREDIT_W-1:0]               price_arr [PSLOTS];
  logic [PSLOTS-1:0][STOCK_W-1:0]    stock_all;

  for (genvar g = 0; g < PSLOTS; g++) begin : g_price
    if (g < NUM_PRODUCTS) begin : g_real
      assign price_arr[g] = price_tbl[price_lsb(g, CREDIT_W) +: CREDIT_W];
    end else begin : g_pad
      assign price_arr[g] = '0;
    end
  end

  assign price_sel = price_arr[sel_id_q];

  // Per-slot stock counter: restock and a CHECK decrement net out, then saturate.
  for (genvar g = 0; g < PSLOTS; g++) begin : g_stock
    logic [STOCK_W-1:0] stock_q, stock_d;
    logic [STOCK_W:0]   stock_sum;

    always_comb begin
      stock_sum = {1'b0, stock_q};
      if (restock_valid && (restock_id == ID_W'(g)) && PROD_VALID[g]) begin
        stock_sum = stock_sum + {1'b0, restock_qty};
      end
      if (stock_dec && (sel_id_q == ID_W'(g))) begin
        stock_sum = stock_sum - (STOCK_W+1)'(1);
      end
      stock_d = stock_sum[STOCK_W] ? {STOCK_W{1'b1}} : stock_sum[STOCK_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stock_q <= '0;
      end else begin
        stock_q <= stock_d;
      end
    end

    assign stock_all[g] = stock_q;
  end

  vm_change_unit #(
    .CREDIT_W (CREDIT_W)
  ) u_change (
    .credit    (credit_q),
    .chg_value (greedy_val)
  );

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    sel_id_d       = sel_id_q;
    tmo_d          = '0;
    done_d         = 1'b0;
    sold_out_d     = 1'b0;
    insufficient_d = 1'b0;
    stock_dec      = 1'b0;

    coin_sum    = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value);
    coin_window = (state_q == S_IDLE) || (state_q == S_COLLECT);
    coin_accept = coin_valid && coin_window && !coin_sum[CREDIT_W];
    coin_reject = coin_valid && !coin_accept;
    timeout     = (state_q == S_COLLECT) && (tmo_q == TMO_W'(TIMEOUT_CYC));

    case (state_q)
      S_IDLE: begin
        if (coin_accept) begin
          credit_d = coin_sum[CREDIT_W-1:0];
          state_d  = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (coin_accept) begin
          credit_d = coin_sum[CREDIT_W-1:0];
        end
        if (refund_req || timeout) begin
          state_d = S_CHANGE;
        end else if (sel_valid) begin
          sel_id_d = sel_id;
          state_d  = S_CHECK;
        end else if (!coin_valid) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_CHECK: begin
        state_d = S_COLLECT;
        if (!PROD_VALID[sel_id_q] || (stock_all[sel_id_q] == '0)) begin
          sold_out_d = 1'b1;
        end else if (credit_q < price_sel) begin
          insufficient_d = 1'b1;
        end else begin
          credit_d  = credit_q - price_sel;
          stock_dec = 1'b1;
          state_d   = S_VEND;
        end
      end
      S_VEND: begin
        if (vend_ready) begin
          if (credit_q != '0) begin
            state_d = S_CHANGE;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_CHANGE: begin
        if (credit_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (chg_ready) begin
          credit_d = credit_q - greedy_val;
          if (credit_q == greedy_val) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      credit_q       <= '0;
      sel_id_q       <= '0;
      tmo_q          <= '0;
      done_q         <= 1'b0;
      sold_out_q     <= 1'b0;
      insufficient_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      sel_id_q       <= sel_id_d;
      tmo_q          <= tmo_d;
      done_q         <= done_d;
      sold_out_q     <= sold_out_d;
      insufficient_q <= insufficient_d;
    end
  end

  assign vend_valid   = (state_q == S_VEND);
  assign vend_id      = vend_valid ? sel_id_q : '0;
  assign chg_valid    = (state_q == S_CHANGE) && (credit_q != '0);
  assign chg_value    = chg_valid ? greedy_val : '0;
  assign sold_out     = sold_out_q;
  assign insufficient = insufficient_q;
  assign credit       = credit_q;
  assign done         = done_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// tb/tb_vending_machine_multi.sv - directed and randomized checks against a transaction-level model
module tb_vending_machine_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        coin_valid;
  logic [3:0]  coin_value;
  logic        coin_reject;
  logic        sel_valid;
  logic [1:0]  sel_id;
  logic        refund_req;
  logic [31:0] price_tbl;
  logic        restock_valid;
  logic [1:0]  restock_id;
  logic [3:0]  restock_qty;
  logic        vend_valid;
  logic [1:0]  vend_id;
  logic        vend_ready;
  logic        chg_valid;
  logic [7:0]  chg_value;
  logic        chg_ready;
  logic        sold_out;
  logic        insufficient;
  logic [7:0]  credit;
  logic        done;

  int total = 0;
  int bad   = 0;
  int m_credit;
  int m_stock [4];
  int m_price [4];

  vending_machine_multi #(
    .NUM_PRODUCTS (4),
    .CREDIT_W     (8),
    .STOCK_W      (4),
    .TIMEOUT_CYC  (255)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .coin_valid    (coin_valid),
    .coin_value    (coin_value),
    .coin_reject   (coin_reject),
    .sel_valid     (sel_valid),
    .sel_id        (sel_id),
    .refund_req    (refund_req),
    .price_tbl     (price_tbl),
    .restock_valid (restock_valid),
    .restock_id    (restock_id),
    .restock_qty   (restock_qty),
    .vend_valid    (vend_valid),
    .vend_id       (vend_id),
    .vend_ready    (vend_ready),
    .chg_valid     (chg_valid),
    .chg_value     (chg_value),
    .chg_ready     (chg_ready),
    .sold_out      (sold_out),
    .insufficient  (insufficient),
    .credit        (credit),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int greedy(input int c);
    if (c >= 10) return 10;
    if (c >= 5) return 5;
    if (c >= 1) return 1;
    return 0;
  endfunction

  task automatic set_prices();
    for (int k = 0; k < 4; k++) price_tbl[k*8 +: 8] = 8'(m_price[k]);
  endtask

  task automatic restock(input int id, input int qty);
    restock_valid = 1'b1;
    restock_id    = 2'(id);
    restock_qty   = 4'(qty);
    tick();
    restock_valid = 1'b0;
    m_stock[id] = (m_stock[id] + qty > 15) ? 15 : m_stock[id] + qty;
  endtask

  task automatic coin(input int v, input bit accepting);
    bit exp_rej;
    coin_valid = 1'b1;
    coin_value = 4'(v);
    #1;
    exp_rej = !accepting || (m_credit + v > 255);
    chk("coin_reject", coin_reject, exp_rej);
    tick();
    coin_valid = 1'b0;
    if (!exp_rej) m_credit += v;
    chk("credit_after_coin", credit, m_credit);
  endtask

  task automatic refund();
    refund_req = 1'b1;
    tick();
    refund_req = 1'b0;
  endtask

  task automatic select_prod(input int id, input bit rs, input int rs_id, input int rs_qty,
                             output int outcome);
    sel_valid = 1'b1;
    sel_id    = 2'(id);
    tick();
    sel_valid = 1'b0;
    if (rs) begin
      restock_valid = 1'b1;
      restock_id    = 2'(rs_id);
      restock_qty   = 4'(rs_qty);
    end
    chk("check_cycle_no_vend", vend_valid, 0);
    tick();
    restock_valid = 1'b0;
    if (m_stock[id] == 0) begin
      outcome = 0;
    end else if (m_credit < m_price[id]) begin
      outcome = 1;
    end else begin
      outcome = 2;
      m_credit -= m_price[id];
      m_stock[id] -= 1;
    end
    if (rs) m_stock[rs_id] = (m_stock[rs_id] + rs_qty > 15) ? 15 : m_stock[rs_id] + rs_qty;
    chk("sold_out", sold_out, outcome == 0);
    chk("insufficient", insufficient, outcome == 1);
    chk("vend_valid", vend_valid, outcome == 2);
    chk("credit_after_check", credit, m_credit);
    if (outcome == 2) chk("vend_id", vend_id, id);
  endtask

  task automatic take_vend(input int id, input int delay);
    for (int d = 0; d < delay; d++) begin
      chk("vend_hold_valid", vend_valid, 1);
      chk("vend_hold_id", vend_id, id);
      tick();
    end
    vend_ready = 1'b1;
    #1;
    chk("vend_valid_at_ready", vend_valid, 1);
    @(posedge clk);
    #1;
    vend_ready = 1'b0;
    chk("vend_released", vend_valid, 0);
    chk("done_after_vend", done, m_credit == 0);
    chk("chg_after_vend", chg_valid, m_credit != 0);
  endtask

  task automatic drain(input int max_stall);
    int g;
    int st;
    while (m_credit > 0) begin
      g  = greedy(m_credit);
      st = $urandom_range(0, max_stall);
      for (int s = 0; s < st; s++) begin
        chk("chg_hold_valid", chg_valid, 1);
        chk("chg_hold_value", chg_value, g);
        tick();
      end
      chg_ready = 1'b1;
      #1;
      chk("chg_valid", chg_valid, 1);
      chk("chg_value", chg_value, g);
      @(posedge clk);
      #1;
      chg_ready = 1'b0;
      m_credit -= g;
      chk("credit_after_chg", credit, m_credit);
      if (m_credit > 0) chk("done_early", done, 0);
    end
    chk("done_after_chg", done, 1);
    chk("chg_idle", chg_valid, 0);
  endtask

  task automatic check_quiet(input string tag);
    chk(tag, {coin_reject, vend_valid, vend_id, chg_valid, chg_value, sold_out, insufficient,
              credit, done}, 0);
  endtask

  initial begin
    int outcome;
    int wait_n;
    int coin_set [4];
    coin_set = '{1, 2, 5, 10};

    rst = 1'b1;
    coin_valid = 1'b0; coin_value = '0; sel_valid = 1'b0; sel_id = '0; refund_req = 1'b0;
    restock_valid = 1'b0; restock_id = '0; restock_qty = '0; vend_ready = 1'b0; chg_ready = 1'b0;
    m_credit = 0;
    for (int k = 0; k < 4; k++) m_stock[k] = 0;
    m_price = '{30, 15, 20, 7};
    set_prices();
    tick();
    tick();
    check_quiet("reset_outputs");
    rst = 1'b0;
    tick();
    check_quiet("post_reset_outputs");

    // Change-giving purchase.
    restock(1, 3);
    coin(10, 1);
    coin(10, 1);
    select_prod(1, 0, 0, 0, outcome);
    take_vend(1, 3);
    drain(2);

    // Exact money: done follows the vend handshake directly.
    restock(2, 1);
    coin(10, 1);
    coin(10, 1);
    select_prod(2, 0, 0, 0, outcome);
    take_vend(2, 0);

    // Sold out, insufficient, then refund 10,1,1.
    tick();
    coin(10, 1);
    coin(1, 1);
    coin(1, 1);
    select_prod(0, 0, 0, 0, outcome);
    select_prod(1, 0, 0, 0, outcome);
    refund();
    drain(1);

    // Overflow boundary, then stalled change with a coin arriving mid-CHANGE.
    for (int i = 0; i < 25; i++) coin(10, 1);
    coin(8, 0 == 1 ? 0 : 1);
    coin(5, 1);
    coin(1, 1);
    refund();
    for (int s = 0; s < 5; s++) begin
      if (s == 2) begin
        coin(3, 0);
      end else begin
        chk("stall_chg_valid", chg_valid, 1);
        chk("stall_chg_value", chg_value, 10);
        tick();
      end
    end
    drain(0);

    // Inactivity timeout refund.
    coin(5, 1);
    coin(1, 1);
    coin(1, 1);
    wait_n = 0;
    while (chg_valid !== 1'b1 && wait_n < 300) begin
      tick();
      wait_n++;
    end
    chk("timeout_fired", chg_valid, 1);
    chk("timeout_window", (wait_n >= 255) && (wait_n <= 258), 1);
    drain(1);

    // Reset in the middle of CHANGE discards credit and stock.
    coin(10, 1);
    coin(10, 1);
    refund();
    chk("pre_reset_chg", chg_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check_quiet("async_reset_outputs");
    tick();
    check_quiet("held_reset_outputs");
    rst = 1'b0;
    m_credit = 0;
    for (int k = 0; k < 4; k++) m_stock[k] = 0;
    tick();
    coin(5, 1);
    select_prod(1, 0, 0, 0, outcome);
    refund();
    drain(0);

    // Randomized transactions against the model.
    for (int k = 0; k < 4; k++) m_price[k] = $urandom_range(1, 40);
    set_prices();
    for (int t = 0; t < 40; t++) begin
      tick();
      if ($urandom_range(0, 2) != 0) restock($urandom_range(0, 3), $urandom_range(0, 15));
      for (int c = 0; c < $urandom_range(1, 4); c++) coin(coin_set[$urandom_range(0, 3)], 1);
      if ($urandom_range(0, 3) == 0) begin
        refund();
        drain(2);
      end else begin
        int id;
        id = $urandom_range(0, 3);
        select_prod(id, $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 15),
                    outcome);
        if (outcome == 2) begin
          take_vend(id, $urandom_range(0, 2));
          if (m_credit > 0) drain(2);
        end else begin
          refund();
          drain(2);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
